memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Responder side of the video memory read channel that `background_controller`, the sprite controller and similar blocks drive through `memory_address` / `rvalid` / `rready`.
- Arbitrates up to N_CH requesters onto one single-port SPRAM (16K x 16, 1-cycle read latency).
- Grants use round-robin priority.
- Also carries a non-stalling CPU write path with byte enables.
- Sits between the video requesters and the SPRAM primitive.

Parameters:
- N_CH, 4, number of read requester channels (2..8).
- MEM_ADDR_BITS, 14, SPRAM word address width; upper request address bits are ignored.

Ports:
- CLK  input  1  clock.
- RSTb  input  1  synchronous, active-low reset.
- req_address  input  16*N_CH  word address per channel; channel i at bits [16*i+15:16*i].
- req_valid  input  N_CH  per-channel read request (the requester's rvalid).
- req_ready  output  N_CH  per-channel single-cycle data-valid strobe (the requester's rready).
- req_data  output  16  read data, shared by all channels, valid while any req_ready bit is high.
- cpu_wr  input  1  CPU write strobe.
- cpu_address  input  16  CPU write word address.
- cpu_data  input  16  CPU write data.
- cpu_byte_en  input  2  byte enables; [0] = bits 7:0, [1] = bits 15:8.
- mem_address  output  MEM_ADDR_BITS  SPRAM address.
- mem_wr_data  output  16  SPRAM write data.
- mem_wren  output  1  SPRAM write enable.
- mem_maskwren  output  4  SPRAM nibble write mask.
- mem_rd_data  input  16  SPRAM read data, valid the cycle after the address is presented.

Behaviour:
- **Requester contract:**
  - A requester holds address and req_valid stable until it sees req_ready high.
  - A request is identified by req_valid high. req_valid still high in the cycle after its req_ready is a NEW request.
- **Issue cycle t (combinational):**
  - eligible[i] = req_valid[i] & ~(pend_valid & pend_id==i).
  - If cpu_wr=1:
    - mem_wren=1, mem_address=cpu_address[MEM_ADDR_BITS-1:0], mem_wr_data=cpu_data.
    - mem_maskwren={be[1],be[1],be[0],be[0]}.
    - No read is granted.
  - Else, if any channel is eligible:
    - grant = first eligible channel scanning rr_ptr, rr_ptr+1, … modulo N_CH.
    - mem_address=req_address[grant], mem_wren=0, mem_maskwren=4'b0000.
  - Idle: mem_address=0, mem_wren=0, mem_maskwren=0, mem_wr_data=0.
  - mem_wr_data is 0 whenever cpu_wr=0.
- **Edge ending cycle t, on a grant:**
  - pend_valid<=1, pend_id<=grant.
  - rr_ptr<=(grant+1) mod N_CH.
  - With no grant: pend_valid<=0 and rr_ptr is unchanged.
- **Response cycle t+1:**
  - req_ready[pend_id]=pend_valid, all other bits 0.
  - req_data=mem_rd_data when pend_valid, else 0.
- **Latency and throughput:**
  - Minimum req_valid-to-req_ready latency is 1 cycle.
  - One read per cycle aggregate.
  - The same channel is not granted in the cycle its response is pending.
- **Fairness:** no channel waits more than N_CH grant cycles, plus CPU write cycles, once valid.
- **CPU write priority:**
  - A CPU write always wins and never stalls.
  - A read pending from t-1 still completes in the write cycle, because the SPRAM output holds the previous read.
  - cpu_byte_en=2'b00 with cpu_wr=1 occupies the port with mask 0, so no write takes effect.
- **Reset (RSTb=0 at an edge):**
  - pend_valid=0, rr_ptr=0.
  - Outputs: req_ready=0, req_data=0, mem_wren=0, mem_maskwren=0, mem_address=0, mem_wr_data=0.
  - An in-flight read is dropped with no req_ready.
  - While RSTb=0, no grants are issued and no CPU writes reach memory.
- **Width rules:** address truncation to MEM_ADDR_BITS is silent, so addresses 0x4000 and 0x0000 alias.
- **Size:** no other state; no FSM beyond pend/rr_ptr. Target ~150-250 lines of RTL.

Test Plan:
- **Single read:** channel 0 asserts req_valid with address 0x0123; memory model returns 0xBEEF.
  - Required: mem_address=0x123 in cycle t.
  - Required: req_ready=4'b0001 and req_data=0xBEEF in t+1 only.
- **Contention:** all 4 channels held valid continuously, each re-requesting one cycle after its ready.
  - Required: grants run 0,1,2,3,0,… with rr_ptr starting at 0.
  - Required: one req_ready per cycle after the first; no channel granted twice in consecutive cycles.
- **CPU write during contention:** cpu_wr=1 at address 0x0010, data 0xA5C3, cpu_byte_en=2'b10, while channel 1 is valid.
  - Required: mem_wren=1, mem_maskwren=4'b1100, no grant that cycle; channel 1 is granted the next cycle.
  - Then channel 1 reads 0x0010 and must return 0xA5xx, with the low byte unchanged.
- **Reset mid-operation:** RSTb low at the edge immediately after a grant.
  - Required: req_ready stays 0 in the following cycle.
  - After release, the first grant with channels 2 and 0 both valid goes to channel 0.
- **Back-to-back same channel:** channel 3 keeps req_valid high for 4 cycles with no other traffic.
  - Required: grants in alternate cycles only, giving req_ready[3] pulses at t+1 and t+3.
- **Address aliasing:** request address 0xC005.
  - Required: mem_address=14'h0005.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Video memory read channel plus CPU write path and SPRAM port, bundled
// between the requesters/CPU/memory (master) and the arbiter (slave).
interface memory_arbiter_if #(
    parameter int N_CH          = 4,
    parameter int MEM_ADDR_BITS = 14
);
    logic [16*N_CH-1:0]      req_address;
    logic [N_CH-1:0]         req_valid;
    logic [N_CH-1:0]         req_ready;
    logic [15:0]             req_data;
    logic                    cpu_wr;
    logic [15:0]             cpu_address;
    logic [15:0]             cpu_data;
    logic [1:0]              cpu_byte_en;
    logic [MEM_ADDR_BITS-1:0] mem_address;
    logic [15:0]             mem_wr_data;
    logic                    mem_wren;
    logic [3:0]              mem_maskwren;
    logic [15:0]             mem_rd_data;

    modport master (
        output req_address, req_valid, cpu_wr, cpu_address, cpu_data,
               cpu_byte_en, mem_rd_data,
        input  req_ready, req_data, mem_address, mem_wr_data, mem_wren,
               mem_maskwren
    );

    modport slave (
        input  req_address, req_valid, cpu_wr, cpu_address, cpu_data,
               cpu_byte_en, mem_rd_data,
        output req_ready, req_data, mem_address, mem_wr_data, mem_wren,
               mem_maskwren
    );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter of N_CH video read requesters onto one single-port
// 16-bit SPRAM with 1-cycle read latency. CPU writes take the port whenever
// they occur; the read granted in the previous cycle still completes because
// the SPRAM output holds its last read during a write.
module memory_arbiter #(
    parameter int N_CH          = 4,
    parameter int MEM_ADDR_BITS = 14
) (
    input logic              CLK,
    input logic              RSTb,
    memory_arbiter_if.slave  bus
);
    localparam int ID_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     pend_valid;
    logic [ID_W-1:0]          pend_id;
    logic [ID_W-1:0]          rr_ptr;
    logic                     grant_vld;
    logic [ID_W-1:0]          grant_id;
    logic [N_CH-1:0]          eligible;
    logic [MEM_ADDR_BITS-1:0] ch_addr [N_CH];
    logic                     unused_addr_bits;

    // Upper address bits are dropped on purpose: 0x4000 aliases 0x0000.
    assign unused_addr_bits = ^{bus.req_address, bus.cpu_address};

    for (genvar c = 0; c < N_CH; c++) begin : g_addr
        assign ch_addr[c] = bus.req_address[16*c +: MEM_ADDR_BITS];
    end

    // A channel whose response is due this cycle cannot be re-granted yet.
    always_comb begin
        eligible = bus.req_valid;
        if (pend_valid) eligible[pend_id] = 1'b0;
    end

    // First eligible channel scanning from rr_ptr; CPU writes and reset block reads.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_CH; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_CH);
            if (!grant_vld && eligible[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
        if (!RSTb || bus.cpu_wr) begin
            grant_vld = 1'b0;
            grant_id  = '0;
        end
    end

    // SPRAM port drive: CPU write, granted read address, or all zero when idle.
    always_comb begin
        bus.mem_address  = '0;
        bus.mem_wr_data  = '0;
        bus.mem_wren     = 1'b0;
        bus.mem_maskwren = 4'b0000;
        if (RSTb) begin
            if (bus.cpu_wr) begin
                bus.mem_address  = bus.cpu_address[MEM_ADDR_BITS-1:0];
                bus.mem_wr_data  = bus.cpu_data;
                bus.mem_wren     = 1'b1;
                bus.mem_maskwren = {bus.cpu_byte_en[1], bus.cpu_byte_en[1],
                                    bus.cpu_byte_en[0], bus.cpu_byte_en[0]};
            end else if (grant_vld) begin
                bus.mem_address = ch_addr[grant_id];
            end
        end
    end

    // Track the outstanding read and advance the round-robin pointer past it.
    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            pend_valid <= 1'b0;
            pend_id    <= '0;
            rr_ptr     <= '0;
        end else begin
            pend_valid <= grant_vld;
            if (grant_vld) begin
                pend_id <= grant_id;
                rr_ptr  <= ID_W'((int'(grant_id) + 1) % N_CH);
            end
        end
    end

    // Response strobe to the owning channel with the SPRAM read data.
    always_comb begin
        bus.req_ready = '0;
        bus.req_data  = '0;
        if (pend_valid) begin
            bus.req_ready[pend_id] = 1'b1;
            bus.req_data           = bus.mem_rd_data;
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: SPRAM model, directed scenarios and a random
// phase, all checked against a transaction-level reference model.
module tb_memory_arbiter;
    localparam int N_CH = 4;
    localparam int MAB  = 14;
    localparam int MEMW = 1 << MAB;

    logic CLK;
    logic RSTb;

    memory_arbiter_if #(.N_CH(N_CH), .MEM_ADDR_BITS(MAB)) bus ();

    memory_arbiter #(.N_CH(N_CH), .MEM_ADDR_BITS(MAB)) dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SPRAM: nibble-masked write, otherwise registered read; output holds on write.
    logic [15:0] spram [MEMW];
    always @(posedge CLK) begin
        logic [15:0] w;
        if (bus.mem_wren) begin
            w = spram[bus.mem_address];
            for (int n = 0; n < 4; n++)
                if (bus.mem_maskwren[n]) w[4*n +: 4] = bus.mem_wr_data[4*n +: 4];
            spram[bus.mem_address] = w;
        end else begin
            bus.mem_rd_data <= spram[bus.mem_address];
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Reference model state: which channel owes a response, its data, rotation start.
    int          m_pend;
    int          m_ptr;
    logic [15:0] m_pend_data;
    logic [15:0] ref_mem [MEMW];
    logic        rst_pulse;

    logic [N_CH-1:0] obs_ready;
    logic [15:0]     obs_data;
    logic [15:0]     obs_wdata;
    logic [MAB-1:0]  obs_addr;
    logic            obs_wren;
    logic [3:0]      obs_mask;

    task automatic step();
        int              grant;
        int              a;
        logic [MAB-1:0]  e_addr;
        logic [15:0]     e_wdata;
        logic            e_wren;
        logic [3:0]      e_mask;
        logic [N_CH-1:0] e_ready;
        logic [15:0]     e_data;
        logic [15:0]     ra;
        @(negedge CLK);
        grant   = -1;
        e_addr  = '0;
        e_wdata = '0;
        e_wren  = 1'b0;
        e_mask  = 4'b0000;
        if (RSTb) begin
            if (bus.cpu_wr) begin
                e_wren  = 1'b1;
                e_addr  = MAB'(bus.cpu_address % MEMW);
                e_wdata = bus.cpu_data;
                e_mask  = {{2{bus.cpu_byte_en[1]}}, {2{bus.cpu_byte_en[0]}}};
            end else begin
                for (int k = 0; k < N_CH; k++) begin
                    int c;
                    c = (m_ptr + k) % N_CH;
                    if (grant < 0 && bus.req_valid[c] && c != m_pend) grant = c;
                end
                if (grant >= 0) begin
                    ra     = bus.req_address[16*grant +: 16];
                    e_addr = MAB'(ra % MEMW);
                end
            end
        end
        e_ready = (m_pend >= 0) ? N_CH'(1 << m_pend) : '0;
        e_data  = (m_pend >= 0) ? m_pend_data : 16'h0;

        obs_ready = bus.req_ready;
        obs_data  = bus.req_data;
        obs_addr  = bus.mem_address;
        obs_wren  = bus.mem_wren;
        obs_mask  = bus.mem_maskwren;
        obs_wdata = bus.mem_wr_data;
        check_val("mem_address", 32'(obs_addr), 32'(e_addr));
        check_val("mem_wren", 32'(obs_wren), 32'(e_wren));
        check_val("mem_maskwren", 32'(obs_mask), 32'(e_mask));
        check_val("mem_wr_data", 32'(obs_wdata), 32'(e_wdata));
        check_val("req_ready", 32'(obs_ready), 32'(e_ready));
        check_val("req_data", 32'(obs_data), 32'(e_data));

        if (rst_pulse) RSTb = 1'b0;
        if (!RSTb) begin
            m_pend = -1;
            m_ptr  = 0;
        end else begin
            if (e_wren) begin
                a = int'(e_addr);
                if (bus.cpu_byte_en[0]) ref_mem[a][7:0]  = bus.cpu_data[7:0];
                if (bus.cpu_byte_en[1]) ref_mem[a][15:8] = bus.cpu_data[15:8];
            end
            if (grant >= 0) begin
                m_pend      = grant;
                m_pend_data = ref_mem[int'(e_addr)];
                m_ptr       = (grant + 1) % N_CH;
            end else begin
                m_pend = -1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic v, input logic [15:0] a);
        bus.req_valid[ch]             = v;
        bus.req_address[16*ch +: 16] = a;
    endtask

    task automatic poke(input int a, input logic [15:0] d);
        spram[a]   = d;
        ref_mem[a] = d;
    endtask

    task automatic clear_and_reset();
        bus.req_valid = '0;
        bus.cpu_wr    = 1'b0;
        RSTb          = 1'b0;
        step();
        RSTb = 1'b1;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [15:0] a;
        a        = 16'($urandom);
        a[13:5]  = '0;
        return a;
    endfunction

    initial begin
        logic [15:0] v;
        m_pend      = -1;
        m_ptr       = 0;
        m_pend_data = '0;
        rst_pulse   = 1'b0;
        for (int i = 0; i < MEMW; i++) begin
            v = 16'($urandom);
            spram[i]   = v;
            ref_mem[i] = v;
        end
        RSTb            = 1'b0;
        bus.req_valid   = '0;
        bus.req_address = '0;
        bus.cpu_wr      = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_data    = '0;
        bus.cpu_byte_en = 2'b00;
        @(posedge CLK);
        #1;

        // Reset state and single read on channel 0
        clear_and_reset();
        poke(16'h0123, 16'hBEEF);
        set_ch(0, 1'b1, 16'h0123);
        step();
        check_val("single_addr", 32'(obs_addr), 32'h123);
        check_val("single_ready_t", 32'(obs_ready), 32'h0);
        step();
        check_val("single_ready_t1", 32'(obs_ready), 32'h1);
        check_val("single_data", 32'(obs_data), 32'hBEEF);
        set_ch(0, 1'b0, 16'h0);
        step();
        check_val("single_ready_t2", 32'(obs_ready), 32'h0);

        // Contention: all four channels continuously requesting
        clear_and_reset();
        for (int i = 0; i < N_CH; i++) set_ch(i, 1'b1, 16'(16'h0100 + i));
        for (int k = 0; k < 12; k++) begin
            step();
            if (k == 0) check_val("contend_first", 32'(obs_ready), 32'h0);
            else        check_val("contend_ready", 32'(obs_ready), 32'(1 << ((k - 1) % N_CH)));
        end

        // CPU write with upper byte enable while channel 1 waits
        clear_and_reset();
        poke(16'h0010, 16'h1234);
        set_ch(1, 1'b1, 16'h0200);
        bus.cpu_wr      = 1'b1;
        bus.cpu_address = 16'h0010;
        bus.cpu_data    = 16'hA5C3;
        bus.cpu_byte_en = 2'b10;
        step();
        check_val("cpuwr_wren", 32'(obs_wren), 32'h1);
        check_val("cpuwr_mask", 32'(obs_mask), 32'hC);
        check_val("cpuwr_addr", 32'(obs_addr), 32'h10);
        bus.cpu_wr = 1'b0;
        step();
        check_val("cpuwr_nogrant", 32'(obs_ready), 32'h0);
        check_val("cpuwr_ch1_addr", 32'(obs_addr), 32'h200);
        step();
        check_val("cpuwr_ch1_ready", 32'(obs_ready), 32'h2);
        set_ch(1, 1'b1, 16'h0010);
        step();
        check_val("cpuwr_rd_addr", 32'(obs_addr), 32'h10);
        step();
        check_val("cpuwr_rd_ready", 32'(obs_ready), 32'h2);
        check_val("cpuwr_rd_data", 32'(obs_data), 32'hA534);
        set_ch(1, 1'b0, 16'h0);

        // Reset at the edge right after a grant
        clear_and_reset();
        set_ch(2, 1'b1, 16'h0042);
        rst_pulse = 1'b1;
        step();
        rst_pulse = 1'b0;
        check_val("rst_grant_addr", 32'(obs_addr), 32'h42);
        RSTb = 1'b1;
        set_ch(0, 1'b1, 16'h0077);
        step();
        check_val("rst_dropped", 32'(obs_ready), 32'h0);
        check_val("rst_first_grant", 32'(obs_addr), 32'h77);
        step();
        check_val("rst_ch0_ready", 32'(obs_ready), 32'h1);
        bus.req_valid = '0;

        // Back-to-back requests on channel 3 alone
        clear_and_reset();
        set_ch(3, 1'b1, 16'h0300);
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("b2b_ready", 32'(obs_ready), (k == 1 || k == 3) ? 32'h8 : 32'h0);
        end
        set_ch(3, 1'b0, 16'h0);
        step();
        check_val("b2b_tail", 32'(obs_ready), 32'h0);

        // Address aliasing above the SPRAM depth
        clear_and_reset();
        set_ch(0, 1'b1, 16'hC005);
        step();
        check_val("alias_addr", 32'(obs_addr), 32'h5);
        step();
        set_ch(0, 1'b0, 16'h0);
        step();

        // Random traffic
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (obs_ready[i]) begin
                    set_ch(i, ($urandom % 4) != 0, rand_addr());
                end else if (!bus.req_valid[i] && ($urandom % 3) == 0) begin
                    set_ch(i, 1'b1, rand_addr());
                end
            end
            bus.cpu_wr      = ($urandom % 5) == 0;
            bus.cpu_address = rand_addr();
            bus.cpu_data    = 16'($urandom);
            bus.cpu_byte_en = 2'($urandom);
            RSTb            = ($urandom % 64) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
